// File: rtl/spi_flash_cmd_seq_if.sv
// Bus bundle between the flash command sequencer, its client
// and the byte-level spi_master.
interface spi_flash_cmd_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic        cmd_addr_en;
    logic [23:0] cmd_addr;
    logic [3:0]  cmd_dummy;
    logic        cmd_wr;
    logic [15:0] cmd_len;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic        spi_nCS_ctrl;
    logic        spi_CPOL;
    logic        spi_CPHA;
    logic [15:0] spi_clk_div;
    logic        spi_wr_req;
    logic        spi_wr_ack;
    logic [7:0]  spi_tx_byte;
    logic [7:0]  spi_rx_byte;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_addr_en, cmd_addr,
        input  cmd_dummy, cmd_wr, cmd_len,
        input  tx_data, tx_valid, rx_ready,
        input  spi_wr_ack, spi_rx_byte,
        output cmd_ready, tx_ready, rx_data, rx_valid,
        output busy, done,
        output spi_nCS_ctrl, spi_CPOL, spi_CPHA, spi_clk_div,
        output spi_wr_req, spi_tx_byte
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_addr_en, cmd_addr,
        output cmd_dummy, cmd_wr, cmd_len,
        output tx_data, tx_valid, rx_ready,
        output spi_wr_ack, spi_rx_byte,
        input  cmd_ready, tx_ready, rx_data, rx_valid,
        input  busy, done,
        input  spi_nCS_ctrl, spi_CPOL, spi_CPHA, spi_clk_div,
        input  spi_wr_req, spi_tx_byte
    );
endinterface

// File: rtl/spi_flash_cmd_seq.sv
// Flash command sequencer: opcode, address, dummy and data
// bytes issued one at a time to spi_master; owns nCS.
module spi_flash_cmd_seq #(
    parameter logic [15:0] CLK_DIV  = 16'd4,
    parameter logic        CPOL     = 1'b0,
    parameter logic        CPHA     = 1'b0,
    parameter int          CS_SETUP = 2,
    parameter int          CS_GAP   = 4
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    spi_flash_cmd_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_OPC,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

    state_t      r_state, w_state_nx;
    logic [7:0]  r_cnt, w_cnt_nx;
    logic [3:0]  r_idx, w_idx_nx;
    logic [15:0] r_rem, w_rem_nx;
    logic [7:0]  r_opc, w_opc_nx;
    logic        r_addr_en, w_addr_en_nx;
    logic [23:0] r_addr, w_addr_nx;
    logic [3:0]  r_dummy, w_dummy_nx;
    logic        r_wr, w_wr_nx;
    logic        r_req, w_req_nx;
    logic [7:0]  r_tx, w_tx_nx;
    logic        r_ncs, w_ncs_nx;
    logic        r_rxv, w_rxv_nx;
    logic [7:0]  r_rxd, w_rxd_nx;
    logic        r_txr, w_txr_nx;
    logic        r_done, w_done_nx;

    logic        w_ack;
    state_t      w_after_opc;
    state_t      w_after_addr;
    state_t      w_after_dummy;

    // an ack only counts while a byte request is outstanding
    assign w_ack = r_req & bus.spi_wr_ack;

    // pick the next present phase so absent phases are skipped
    always_comb begin
        w_after_dummy = (r_rem != 16'd0) ? S_DATA : S_HOLD;
        w_after_addr  = (r_dummy != 4'd0) ? S_DUMMY : w_after_dummy;
        w_after_opc   = r_addr_en ? S_ADDR : w_after_addr;
    end

    // next-state and next-output decode of the transaction FSM
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_idx_nx     = r_idx;
        w_rem_nx     = r_rem;
        w_opc_nx     = r_opc;
        w_addr_en_nx = r_addr_en;
        w_addr_nx    = r_addr;
        w_dummy_nx   = r_dummy;
        w_wr_nx      = r_wr;
        w_req_nx     = r_req;
        w_tx_nx      = r_tx;
        w_ncs_nx     = r_ncs;
        w_rxv_nx     = r_rxv;
        w_rxd_nx     = r_rxd;
        w_txr_nx     = 1'b0;
        w_done_nx    = 1'b0;

        if (r_rxv && bus.rx_ready) begin
            w_rxv_nx = 1'b0;
        end
        if (w_ack) begin
            w_req_nx = 1'b0;
        end

        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_opc_nx     = bus.cmd_opcode;
                    w_addr_en_nx = bus.cmd_addr_en;
                    w_addr_nx    = bus.cmd_addr;
                    w_dummy_nx   = bus.cmd_dummy;
                    w_wr_nx      = bus.cmd_wr;
                    w_rem_nx     = bus.cmd_len;
                    w_ncs_nx     = 1'b0;
                    w_cnt_nx     = 8'd0;
                    w_idx_nx     = 4'd0;
                    w_state_nx   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_req_nx   = 1'b1;
                    w_tx_nx    = r_opc;
                    w_state_nx = S_OPC;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            S_OPC: begin
                if (w_ack) begin
                    w_idx_nx   = 4'd0;
                    w_state_nx = w_after_opc;
                end
            end
            S_ADDR: begin
                if (w_ack) begin
                    if (r_idx == 4'd2) begin
                        w_idx_nx   = 4'd0;
                        w_state_nx = w_after_addr;
                    end else begin
                        w_idx_nx = r_idx + 4'd1;
                    end
                end else if (!r_req) begin
                    w_req_nx = 1'b1;
                    unique case (1'b1)
                        r_idx == 4'd0: w_tx_nx = r_addr[23:16];
                        r_idx == 4'd1: w_tx_nx = r_addr[15:8];
                        default:       w_tx_nx = r_addr[7:0];
                    endcase
                end
            end
            S_DUMMY: begin
                if (w_ack) begin
                    if (r_idx == 4'(r_dummy - 4'd1)) begin
                        w_idx_nx   = 4'd0;
                        w_state_nx = w_after_dummy;
                    end else begin
                        w_idx_nx = r_idx + 4'd1;
                    end
                end else if (!r_req) begin
                    w_req_nx = 1'b1;
                    w_tx_nx  = 8'h00;
                end
            end
            S_DATA: begin
                if (w_ack) begin
                    w_rem_nx = r_rem - 16'd1;
                    if (!r_wr) begin
                        w_rxd_nx = bus.spi_rx_byte;
                        w_rxv_nx = 1'b1;
                    end
                    if (r_rem == 16'd1) begin
                        w_state_nx = S_HOLD;
                    end
                end else if (!r_req) begin
                    if (r_wr) begin
                        if (bus.tx_valid) begin
                            w_req_nx = 1'b1;
                            w_tx_nx  = bus.tx_data;
                            w_txr_nx = 1'b1;
                        end
                    end else if (!r_rxv || bus.rx_ready) begin
                        w_req_nx = 1'b1;
                        w_tx_nx  = 8'h00;
                    end
                end
            end
            S_HOLD: begin
                if (!r_rxv) begin
                    w_ncs_nx   = 1'b1;
                    w_done_nx  = 1'b1;
                    w_cnt_nx   = 8'd0;
                    w_state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_ncs_nx   = 1'b1;
                w_req_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // state and registered outputs; reset drops req and raises nCS at once
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_idx     <= 4'd0;
            r_rem     <= 16'd0;
            r_opc     <= 8'd0;
            r_addr_en <= 1'b0;
            r_addr    <= 24'd0;
            r_dummy   <= 4'd0;
            r_wr      <= 1'b0;
            r_req     <= 1'b0;
            r_tx      <= 8'd0;
            r_ncs     <= 1'b1;
            r_rxv     <= 1'b0;
            r_rxd     <= 8'd0;
            r_txr     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_idx     <= w_idx_nx;
            r_rem     <= w_rem_nx;
            r_opc     <= w_opc_nx;
            r_addr_en <= w_addr_en_nx;
            r_addr    <= w_addr_nx;
            r_dummy   <= w_dummy_nx;
            r_wr      <= w_wr_nx;
            r_req     <= w_req_nx;
            r_tx      <= w_tx_nx;
            r_ncs     <= w_ncs_nx;
            r_rxv     <= w_rxv_nx;
            r_rxd     <= w_rxd_nx;
            r_txr     <= w_txr_nx;
            r_done    <= w_done_nx;
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = r_done;
    assign bus.tx_ready     = r_txr;
    assign bus.rx_valid     = r_rxv;
    assign bus.rx_data      = r_rxd;
    assign bus.spi_nCS_ctrl = r_ncs;
    assign bus.spi_wr_req   = r_req;
    assign bus.spi_tx_byte  = r_tx;
    assign bus.spi_CPOL     = CPOL;
    assign bus.spi_CPHA     = CPHA;
    assign bus.spi_clk_div  = CLK_DIV;

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Directed bench for spi_flash_cmd_seq with a behavioural
// spi_master responder and bus monitors.
module tb_spi_flash_cmd_seq;

    localparam int SLV_LAT = 2;
    localparam int CS_GAP  = 4;

    logic clk;
    logic rst_n;

    spi_flash_cmd_seq_if bus ();

    spi_flash_cmd_seq dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    logic [7:0] resp     [0:15];
    logic [7:0] mosi_log [0:15];
    logic [7:0] rx_log   [0:15];
    int mosi_n;
    int rx_n;
    int req_rise;
    int done_cnt;
    int txr_cnt;
    int acc_cnt;
    int bad_rdy;
    int ack_hi;
    int hi_cnt;
    int hi_run;
    int s_wait;
    logic prev_req;

    // spi_master responder plus monitors, sampled 1 ns after negedge
    initial begin
        s_wait   = 0;
        prev_req = 1'b0;
        hi_cnt   = 0;
        hi_run   = 0;
        forever begin
            @(negedge clk);
            #1;
            bus.spi_wr_ack = 1'b0;
            if (!rst_n) begin
                s_wait = 0;
            end else if (bus.spi_wr_req) begin
                if (s_wait == SLV_LAT) begin
                    bus.spi_wr_ack = 1'b1;
                    if (mosi_n < 16) begin
                        bus.spi_rx_byte  = resp[mosi_n];
                        mosi_log[mosi_n] = bus.spi_tx_byte;
                    end
                    if (bus.spi_nCS_ctrl) ack_hi++;
                    mosi_n++;
                    s_wait = 0;
                end else begin
                    s_wait++;
                end
            end
            if (bus.spi_wr_req && !prev_req) req_rise++;
            prev_req = bus.spi_wr_req;
            if (bus.done) done_cnt++;
            if (bus.tx_ready) txr_cnt++;
            if (bus.rx_valid && bus.rx_ready) begin
                if (rx_n < 16) rx_log[rx_n] = bus.rx_data;
                rx_n++;
            end
            if (bus.cmd_valid && bus.cmd_ready) acc_cnt++;
            if (bus.busy && bus.cmd_ready) bad_rdy++;
            if (bus.spi_nCS_ctrl) begin
                hi_cnt++;
            end else begin
                if (hi_cnt != 0) hi_run = hi_cnt;
                hi_cnt = 0;
            end
        end
    end

    task automatic clr_logs();
        mosi_n   = 0;
        rx_n     = 0;
        req_rise = 0;
        done_cnt = 0;
        txr_cnt  = 0;
        acc_cnt  = 0;
        bad_rdy  = 0;
        ack_hi   = 0;
        for (int i = 0; i < 16; i++) begin
            resp[i]     = 8'h00;
            mosi_log[i] = 8'hxx;
            rx_log[i]   = 8'hxx;
        end
    endtask

    task automatic issue(input logic [7:0] opc, input logic aen,
                         input logic [23:0] a, input logic [3:0] dm,
                         input logic wr, input logic [15:0] len);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        bus.cmd_opcode  = opc;
        bus.cmd_addr_en = aen;
        bus.cmd_addr    = a;
        bus.cmd_dummy   = dm;
        bus.cmd_wr      = wr;
        bus.cmd_len     = len;
        bus.cmd_valid   = 1'b1;
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int exp_done);
        int t;
        t = 0;
        while (!(done_cnt >= exp_done && !bus.busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 3000) begin
            n_err++;
            $display("FAIL %s timeout: done=%0d busy=%b want done=%0d idle",
                     nm, done_cnt, bus.busy, exp_done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.spi_nCS_ctrl, bus.spi_wr_req, bus.rx_valid, bus.tx_ready,
             bus.done, bus.busy, bus.cmd_ready} !== 7'b1000001) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 1000001",
                     {bus.spi_nCS_ctrl, bus.spi_wr_req, bus.rx_valid,
                      bus.tx_ready, bus.done, bus.busy, bus.cmd_ready});
        end
        n_cmp++;
        if ({bus.spi_tx_byte, bus.rx_data} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_data got %h want 0000",
                     {bus.spi_tx_byte, bus.rx_data});
        end
        n_cmp++;
        if ({bus.spi_clk_div, bus.spi_CPOL, bus.spi_CPHA} !== {16'd4, 2'b00}) begin
            n_err++;
            $display("FAIL static_cfg got %h/%b%b want 0004/00",
                     bus.spi_clk_div, bus.spi_CPOL, bus.spi_CPHA);
        end
    endtask

    task automatic test_read_id();
        logic [7:0] em [0:3];
        logic [7:0] er [0:2];
        em = '{8'h9F, 8'h00, 8'h00, 8'h00};
        er = '{8'hEF, 8'h40, 8'h18};
        clr_logs();
        resp[1] = 8'hEF;
        resp[2] = 8'h40;
        resp[3] = 8'h18;
        issue(8'h9F, 1'b0, 24'h0, 4'd0, 1'b0, 16'd3);
        wait_idle("read_id", 1);
        n_cmp++;
        if (mosi_n !== 4 || req_rise !== 4) begin
            n_err++;
            $display("FAIL rdid_count got bytes=%0d req=%0d want 4/4",
                     mosi_n, req_rise);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mosi_log[i] !== em[i]) begin
                n_err++;
                $display("FAIL rdid_mosi[%0d] got %h want %h",
                         i, mosi_log[i], em[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rx_log[i] !== er[i]) begin
                n_err++;
                $display("FAIL rdid_rx[%0d] got %h want %h",
                         i, rx_log[i], er[i]);
            end
        end
        n_cmp++;
        if (rx_n !== 3 || done_cnt !== 1 || ack_hi !== 0) begin
            n_err++;
            $display("FAIL rdid_misc got rx=%0d done=%0d ackhi=%0d want 3/1/0",
                     rx_n, done_cnt, ack_hi);
        end
    endtask

    task automatic test_fast_read();
        logic [7:0] em [0:6];
        em = '{8'h0B, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00};
        clr_logs();
        resp[5] = 8'hA5;
        resp[6] = 8'h3C;
        issue(8'h0B, 1'b1, 24'h123456, 4'd1, 1'b0, 16'd2);
        wait_idle("fast_read", 1);
        n_cmp++;
        if (mosi_n !== 7) begin
            n_err++;
            $display("FAIL frd_count got %0d want 7", mosi_n);
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (mosi_log[i] !== em[i]) begin
                n_err++;
                $display("FAIL frd_mosi[%0d] got %h want %h",
                         i, mosi_log[i], em[i]);
            end
        end
        n_cmp++;
        if (rx_n !== 2 || rx_log[0] !== 8'hA5 || rx_log[1] !== 8'h3C) begin
            n_err++;
            $display("FAIL frd_rx got n=%0d %h %h want 2 a5 3c",
                     rx_n, rx_log[0], rx_log[1]);
        end
    endtask

    task automatic test_page_program();
        logic [7:0] em [0:7];
        logic [7:0] txb [0:3];
        int t;
        em  = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        txb = '{8'h11, 8'h22, 8'h33, 8'h44};
        clr_logs();
        issue(8'h02, 1'b1, 24'h000100, 4'd0, 1'b1, 16'd4);
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clk);
            bus.tx_data  = txb[i];
            bus.tx_valid = 1'b1;
            t = 0;
            do begin
                @(posedge clk);
                #1;
                t++;
            end while (!bus.tx_ready && t < 500);
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'hFF;
        end
        wait_idle("page_prog", 1);
        n_cmp++;
        if (mosi_n !== 8 || txr_cnt !== 4) begin
            n_err++;
            $display("FAIL pp_count got bytes=%0d txready=%0d want 8/4",
                     mosi_n, txr_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mosi_log[i] !== em[i]) begin
                n_err++;
                $display("FAIL pp_mosi[%0d] got %h want %h",
                         i, mosi_log[i], em[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] er [0:3];
        int t;
        int r0;
        er = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        clr_logs();
        for (int i = 0; i < 4; i++) resp[4 + i] = er[i];
        bus.rx_ready = 1'b0;
        issue(8'h03, 1'b1, 24'h000010, 4'd0, 1'b0, 16'd4);
        t = 0;
        while (!bus.rx_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        r0 = req_rise;
        repeat (50) @(negedge clk);
        n_cmp++;
        if (req_rise !== r0 || r0 !== 5) begin
            n_err++;
            $display("FAIL bp_stall got req=%0d then %0d want 5 then 5",
                     r0, req_rise);
        end
        n_cmp++;
        if (bus.spi_nCS_ctrl !== 1'b0 || bus.rx_valid !== 1'b1 ||
            bus.rx_data !== 8'hD0) begin
            n_err++;
            $display("FAIL bp_hold got ncs=%b rxv=%b rxd=%h want 0 1 d0",
                     bus.spi_nCS_ctrl, bus.rx_valid, bus.rx_data);
        end
        bus.rx_ready = 1'b1;
        wait_idle("backpressure", 1);
        n_cmp++;
        if (rx_n !== 4) begin
            n_err++;
            $display("FAIL bp_rx_count got %0d want 4", rx_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rx_log[i] !== er[i]) begin
                n_err++;
                $display("FAIL bp_rx[%0d] got %h want %h",
                         i, rx_log[i], er[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        clr_logs();
        @(negedge clk);
        bus.cmd_opcode  = 8'h06;
        bus.cmd_addr_en = 1'b0;
        bus.cmd_dummy   = 4'd0;
        bus.cmd_wr      = 1'b0;
        bus.cmd_len     = 16'd0;
        bus.cmd_valid   = 1'b1;
        t = 0;
        while (!(acc_cnt >= 2 && done_cnt >= 2 && !bus.busy) && t < 1000) begin
            @(negedge clk);
            if (acc_cnt == 1) bus.cmd_opcode = 8'h04;
            if (acc_cnt >= 2) bus.cmd_valid = 1'b0;
            t++;
        end
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if (t >= 1000) begin
            n_err++;
            $display("FAIL b2b timeout acc=%0d done=%0d", acc_cnt, done_cnt);
        end
        n_cmp++;
        if (mosi_n !== 2 || mosi_log[0] !== 8'h06 || mosi_log[1] !== 8'h04) begin
            n_err++;
            $display("FAIL b2b_mosi got n=%0d %h %h want 2 06 04",
                     mosi_n, mosi_log[0], mosi_log[1]);
        end
        n_cmp++;
        if (acc_cnt !== 2 || done_cnt !== 2 || bad_rdy !== 0) begin
            n_err++;
            $display("FAIL b2b_hs got acc=%0d done=%0d rdy_busy=%0d want 2/2/0",
                     acc_cnt, done_cnt, bad_rdy);
        end
        n_cmp++;
        if (hi_run < CS_GAP) begin
            n_err++;
            $display("FAIL b2b_gap got ncs high %0d cycles want >=%0d",
                     hi_run, CS_GAP);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clr_logs();
        issue(8'h03, 1'b1, 24'hABCDEF, 4'd0, 1'b0, 16'd2);
        t = 0;
        while (!(mosi_n == 2 && bus.spi_wr_req) && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bus.spi_tx_byte !== 8'hCD) begin
            n_err++;
            $display("FAIL rst_mid_byte got %h want cd", bus.spi_tx_byte);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.spi_nCS_ctrl, bus.spi_wr_req, bus.rx_valid, bus.busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL rst_mid got ncs/req/rxv/busy %b want 1000",
                     {bus.spi_nCS_ctrl, bus.spi_wr_req, bus.rx_valid, bus.busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr_logs();
        issue(8'h06, 1'b0, 24'h0, 4'd0, 1'b0, 16'd0);
        wait_idle("after_reset", 1);
        n_cmp++;
        if (mosi_n !== 1 || mosi_log[0] !== 8'h06 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL post_rst_cmd got n=%0d %h done=%0d want 1 06 1",
                     mosi_n, mosi_log[0], done_cnt);
        end
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_opcode  = 8'h00;
        bus.cmd_addr_en = 1'b0;
        bus.cmd_addr    = 24'h0;
        bus.cmd_dummy   = 4'd0;
        bus.cmd_wr      = 1'b0;
        bus.cmd_len     = 16'd0;
        bus.tx_data     = 8'h00;
        bus.tx_valid    = 1'b0;
        bus.rx_ready    = 1'b1;
        bus.spi_wr_ack  = 1'b0;
        bus.spi_rx_byte = 8'h00;
        clr_logs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_read_id();
        test_fast_read();
        test_page_program();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
